ppu_ex_mem_ctrl_pipe: RTL and testbench
=======================================

Name: ppu_ex_mem_ctrl_pipe

Overview:
- Control-path slice of the PPU pipeline.
- Holds the combinational next-PC incrementer (PC+4).
- Holds the ID/EX and EX/MEM control-signal pipeline registers.
- Takes the 22-bit control word chosen by the ID-stage NOP mux, carries it through EX and MEM, and decodes per-stage fields for the datapath and the downstream MEM/WB register.

Parameters:
- CW, 22, control-word width; field map below is fixed for CW=22.
- AW, 32, address width of the incrementer.
- INC, 4, incrementer step in bytes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- npc_in  in  AW  current nPC value
- adder_out  out  AW  npc_in + INC
- control_signals  in  CW  ID-stage control word (post NOP mux)
- pipe_hold  in  1  freeze both registers
- idex_flush  in  1  load bubble (all zero) into ID/EX
- ex_control_out  out  CW  ID/EX register contents
- ex_alu_op  out  4  ID/EX [14:11]
- ex_src_op  out  3  ID/EX [17:15]
- ex_branch_instr  out  1  ID/EX [8]
- ex_load_instr  out  1  ID/EX [10]
- ex_rf_enable  out  1  ID/EX [9]
- mem_control_out  out  CW  EX/MEM register contents
- mem_size  out  2  EX/MEM [6:5]
- mem_rw  out  1  EX/MEM [4]
- mem_se  out  1  EX/MEM [3]
- mem_enable  out  1  EX/MEM [0]
- mem_load_instr  out  1  EX/MEM [10]
- mem_rf_enable  out  1  EX/MEM [9]

Behaviour:
- Control word fields:
  - [21:18] reserved, carried unchanged
  - [17:15] source-operand select
  - [14:11] ALU op
  - [10] load
  - [9] RF write enable
  - [8] branch
  - [7] target-address instr
  - [6:5] mem size
  - [4] mem R/W (1 = write)
  - [3] mem sign-extend
  - [2] HI enable
  - [1] LO enable
  - [0] mem enable
- Incrementer:
  - Purely combinational; adder_out = (npc_in + INC) mod 2^AW.
  - Carry discarded: 0xFFFFFFFC -> 0x00000000.
  - Unaffected by reset, hold and flush.
- Register update at each rising clk, priority reset > pipe_hold > idex_flush > normal:
  - reset=0: both registers cleared to all zeros. Every decoded output reads 0, which is the NOP encoding.
  - pipe_hold=1: both registers keep their value; pending flush is ignored that cycle.
  - idex_flush=1: ID/EX <= 0; EX/MEM <= old ID/EX (instruction in EX still advances).
  - Normal: ID/EX <= control_signals; EX/MEM <= old ID/EX.
- Latency:
  - Control word visible on ex_* one cycle after capture.
  - Visible on mem_* two cycles after capture.
  - Full 22-bit word is forwarded, including bits unused at that stage (downstream MEM/WB needs [9], [2], [1]).
- All decoded outputs are continuous slices of their register; no extra logic or delay.
- Reset asserted mid-stream discards all in-flight words on that edge. Release takes effect on the next edge.
- X on control_signals is captured as-is; no sanitising.

Optional Feature:
- Macro PIPE_VALID_EN.
- Defined:
  - Adds outputs ex_valid and mem_valid, 1 bit each.
  - ex_valid is set when ID/EX loads a non-zero word and cleared on reset, flush or zero-word load.
  - mem_valid follows ex_valid one stage later.
  - Both obey the same hold rule as the data.
- Undefined: the ports do not exist; behaviour otherwise identical.

Test Plan:
- Reset: reset=0 for 2 cycles with control_signals=22'h3FFFFF -> ex_control_out=0 and mem_control_out=0, all decoded outputs 0.
- Pipeline flow:
  - Stimulus: cycle N control_signals=22'h008601 (LBU-like), then 0.
  - N+1: ex_src_op=001, ex_alu_op=0000, ex_load_instr=1, ex_rf_enable=1.
  - N+2: mem_enable=1, mem_size=00, mem_rw=0, mem_load_instr=1, mem_rf_enable=1, ex_* = 0.
- Store/branch decode: control_signals=22'h000131 -> ex_branch_instr=1; next cycle mem_rw=1, mem_size=01, mem_enable=1, mem_rf_enable=0.
- Hold and flush:
  - ID/EX=22'h008200, pipe_hold=1, idex_flush=1 for 3 cycles -> both registers unchanged.
  - Drop hold -> ID/EX=0 and EX/MEM=22'h008200 on the next edge.
- Incrementer: npc_in = 0x00000000, 0x00000010, 0xFFFFFFFC -> adder_out = 0x00000004, 0x00000014, 0x00000000, all combinationally (same timestep, no clock).
- With PIPE_VALID_EN: word 22'h008200, then bubble -> ex_valid 1 then 0; mem_valid lags by one cycle; reset clears both.

Source files
------------

// File: rtl/ppu_ex_mem_ctrl_pipe.sv
// ppu_ex_mem_ctrl_pipe
// Control-path slice of the PPU pipeline: the next-PC incrementer (PC+INC)
// and the ID/EX and EX/MEM control-word registers with per-stage decodes.
// Optional feature macro: PIPE_VALID_EN adds ex_valid / mem_valid outputs
// that mark a non-zero (non-NOP) control word in each stage.
// Control word fields (CW=22):
//   [21:18] reserved  [17:15] src select  [14:11] ALU op  [10] load
//   [9] RF write      [8] branch          [7] target-address instr
//   [6:5] mem size    [4] mem R/W (1=wr)  [3] mem sign-extend
//   [2] HI enable     [1] LO enable       [0] mem enable
module ppu_ex_mem_ctrl_pipe #(
  parameter int CW  = 22,
  parameter int AW  = 32,
  parameter int INC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] npc_in,
  output logic [AW-1:0] adder_out,
  input  logic [CW-1:0] control_signals,
  input  logic          pipe_hold,
  input  logic          idex_flush,
  output logic [CW-1:0] ex_control_out,
  output logic [3:0]    ex_alu_op,
  output logic [2:0]    ex_src_op,
  output logic          ex_branch_instr,
  output logic          ex_load_instr,
  output logic          ex_rf_enable,
  output logic [CW-1:0] mem_control_out,
  output logic [1:0]    mem_size,
  output logic          mem_rw,
  output logic          mem_se,
  output logic          mem_enable,
  output logic          mem_load_instr,
  output logic          mem_rf_enable
`ifdef PIPE_VALID_EN
  ,
  output logic          ex_valid,
  output logic          mem_valid
`endif
);

  logic [CW-1:0] idex_r;
  logic [CW-1:0] exmem_r;
  logic [CW-1:0] idex_nxt_s;
  logic [CW-1:0] exmem_nxt_s;

  // Incrementer: carry out of the top bit is dropped, so the PC wraps.
  assign adder_out = npc_in + AW'(INC);

  // Next register contents: reset beats hold, hold beats flush, flush beats normal flow.
  always_comb begin
    idex_nxt_s  = idex_r;
    exmem_nxt_s = exmem_r;
    if (!reset) begin
      idex_nxt_s  = {CW{1'b0}};
      exmem_nxt_s = {CW{1'b0}};
    end else if (pipe_hold) begin
      idex_nxt_s  = idex_r;
      exmem_nxt_s = exmem_r;
    end else if (idex_flush) begin
      idex_nxt_s  = {CW{1'b0}};
      exmem_nxt_s = idex_r;
    end else begin
      idex_nxt_s  = control_signals;
      exmem_nxt_s = idex_r;
    end
  end

  // ID/EX and EX/MEM control registers.
  always_ff @(posedge clk) begin
    idex_r  <= idex_nxt_s;
    exmem_r <= exmem_nxt_s;
  end

`ifdef PIPE_VALID_EN
  logic ex_valid_r;
  logic mem_valid_r;
  logic ex_valid_nxt_s;
  logic mem_valid_nxt_s;

  // Valid bits track the data: EX is valid when it loads a non-zero word,
  // MEM inherits the EX flag as the word advances.
  always_comb begin
    ex_valid_nxt_s  = ex_valid_r;
    mem_valid_nxt_s = mem_valid_r;
    if (!reset) begin
      ex_valid_nxt_s  = 1'b0;
      mem_valid_nxt_s = 1'b0;
    end else if (pipe_hold) begin
      ex_valid_nxt_s  = ex_valid_r;
      mem_valid_nxt_s = mem_valid_r;
    end else if (idex_flush) begin
      ex_valid_nxt_s  = 1'b0;
      mem_valid_nxt_s = ex_valid_r;
    end else begin
      ex_valid_nxt_s  = (control_signals != {CW{1'b0}});
      mem_valid_nxt_s = ex_valid_r;
    end
  end

  // Stage valid registers.
  always_ff @(posedge clk) begin
    ex_valid_r  <= ex_valid_nxt_s;
    mem_valid_r <= mem_valid_nxt_s;
  end

  assign ex_valid  = ex_valid_r;
  assign mem_valid = mem_valid_r;
`endif

  // Stage decodes are plain slices of the registers.
  assign ex_control_out  = idex_r;
  assign ex_alu_op       = idex_r[14:11];
  assign ex_src_op       = idex_r[17:15];
  assign ex_branch_instr = idex_r[8];
  assign ex_load_instr   = idex_r[10];
  assign ex_rf_enable    = idex_r[9];

  assign mem_control_out = exmem_r;
  assign mem_size        = exmem_r[6:5];
  assign mem_rw          = exmem_r[4];
  assign mem_se          = exmem_r[3];
  assign mem_enable      = exmem_r[0];
  assign mem_load_instr  = exmem_r[10];
  assign mem_rf_enable   = exmem_r[9];

endmodule

// File: tb/tb_ppu_ex_mem_ctrl_pipe.sv
// Self-checking bench for ppu_ex_mem_ctrl_pipe: a history-queue model of
// the control-word pipeline checked every cycle, plus directed literal checks.
module tb_ppu_ex_mem_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in;
  logic [31:0] adder_out;
  logic [21:0] control_signals;
  logic        pipe_hold;
  logic        idex_flush;
  logic [21:0] ex_control_out;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_src_op;
  logic        ex_branch_instr, ex_load_instr, ex_rf_enable;
  logic [21:0] mem_control_out;
  logic [1:0]  mem_size;
  logic        mem_rw, mem_se, mem_enable, mem_load_instr, mem_rf_enable;
`ifdef PIPE_VALID_EN
  logic        ex_valid, mem_valid;
`endif

  int checks   = 0;
  int failures = 0;

  ppu_ex_mem_ctrl_pipe dut (
    .clk(clk), .reset(reset), .npc_in(npc_in), .adder_out(adder_out),
    .control_signals(control_signals), .pipe_hold(pipe_hold), .idex_flush(idex_flush),
    .ex_control_out(ex_control_out), .ex_alu_op(ex_alu_op), .ex_src_op(ex_src_op),
    .ex_branch_instr(ex_branch_instr), .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable),
    .mem_control_out(mem_control_out), .mem_size(mem_size), .mem_rw(mem_rw), .mem_se(mem_se),
    .mem_enable(mem_enable), .mem_load_instr(mem_load_instr), .mem_rf_enable(mem_rf_enable)
`ifdef PIPE_VALID_EN
    , .ex_valid(ex_valid), .mem_valid(mem_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of words that entered EX. Newest entry is in EX,
  // the one before it is in MEM. Hold appends nothing; reset wipes history.
  logic [21:0] hist[$];
  bit          known = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      hist.delete();
      hist.push_back(22'h0);
      hist.push_back(22'h0);
      known = 1'b1;
    end else if (known && !pipe_hold) begin
      hist.push_back(idex_flush ? 22'h0 : control_signals);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [21:0] m_ex, m_mem;
    chk("adder", adder_out, npc_in + 32'd4);
    if (known) begin
      m_ex  = hist[hist.size()-1];
      m_mem = hist[hist.size()-2];
      chk("ex_word", {10'd0, ex_control_out}, {10'd0, m_ex});
      chk("ex_alu", {28'd0, ex_alu_op}, {28'd0, m_ex[14:11]});
      chk("ex_src", {29'd0, ex_src_op}, {29'd0, m_ex[17:15]});
      chk("ex_bits", {29'd0, ex_branch_instr, ex_load_instr, ex_rf_enable},
          {29'd0, m_ex[8], m_ex[10], m_ex[9]});
      chk("mem_word", {10'd0, mem_control_out}, {10'd0, m_mem});
      chk("mem_size", {30'd0, mem_size}, {30'd0, m_mem[6:5]});
      chk("mem_bits", {27'd0, mem_rw, mem_se, mem_enable, mem_load_instr, mem_rf_enable},
          {27'd0, m_mem[4], m_mem[3], m_mem[0], m_mem[10], m_mem[9]});
`ifdef PIPE_VALID_EN
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex != 22'h0});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_mem != 22'h0});
`endif
    end
  end

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pipe_hold = 1'b0; idex_flush = 1'b0;
    control_signals = 22'h3FFFFF; npc_in = 32'h0;
    tick(); tick();
    chk("rst_ex", {10'd0, ex_control_out}, 32'h0);
    chk("rst_mem", {10'd0, mem_control_out}, 32'h0);
    chk("rst_dec", {16'd0, ex_alu_op, ex_src_op, ex_branch_instr, ex_load_instr, ex_rf_enable,
        mem_size, mem_rw, mem_se, mem_enable}, 32'h0);

    // LBU-like word flows EX then MEM.
    reset = 1'b1; control_signals = 22'h008601;
    tick();
    chk("flow_ex_src", {29'd0, ex_src_op}, 32'd1);
    chk("flow_ex_alu", {28'd0, ex_alu_op}, 32'd0);
    chk("flow_ex_ld_rf", {30'd0, ex_load_instr, ex_rf_enable}, 32'd3);
    control_signals = 22'h0;
    tick();
    chk("flow_mem", {26'd0, mem_enable, mem_size, mem_rw, mem_load_instr, mem_rf_enable},
        32'b100011);
    chk("flow_ex_zero", {10'd0, ex_control_out}, 32'h0);

    // Store + branch word.
    control_signals = 22'h000131;
    tick();
    chk("st_branch", {31'd0, ex_branch_instr}, 32'd1);
    control_signals = 22'h0;
    tick();
    chk("st_mem", {27'd0, mem_rw, mem_size, mem_enable, mem_rf_enable}, 32'b10110);

    // Hold beats flush; releasing hold lets the flush act.
    control_signals = 22'h000131; tick();
    control_signals = 22'h008200; tick();
    control_signals = 22'h3FFFFF; pipe_hold = 1'b1; idex_flush = 1'b1;
    tick(); tick(); tick();
    chk("hold_ex", {10'd0, ex_control_out}, 32'h008200);
    chk("hold_mem", {10'd0, mem_control_out}, 32'h000131);
    pipe_hold = 1'b0;
    tick();
    chk("flush_ex", {10'd0, ex_control_out}, 32'h0);
    chk("flush_mem", {10'd0, mem_control_out}, 32'h008200);
    idex_flush = 1'b0;

`ifdef PIPE_VALID_EN
    control_signals = 22'h008200; tick();
    chk("v_ex1", {30'd0, ex_valid, mem_valid}, 32'b10);
    control_signals = 22'h0; tick();
    chk("v_ex0", {30'd0, ex_valid, mem_valid}, 32'b01);
    control_signals = 22'h008200; tick(); tick();
    reset = 1'b0; tick();
    chk("v_rst", {30'd0, ex_valid, mem_valid}, 32'b00);
    reset = 1'b1;
`endif

    // Reset in mid-stream discards both in-flight words.
    control_signals = 22'h008601; tick();
    control_signals = 22'h000131; tick();
    chk("mid_pre", {10'd0, mem_control_out}, 32'h008601);
    reset = 1'b0; tick();
    chk("mid_rst", {10'd0, ex_control_out | mem_control_out}, 32'h0);
    reset = 1'b1; control_signals = 22'h0; tick();

    // Incrementer is combinational: no clock edge between these checks.
    npc_in = 32'h00000000; #1; chk("inc0", adder_out, 32'h00000004);
    npc_in = 32'h00000010; #1; chk("inc10", adder_out, 32'h00000014);
    npc_in = 32'hFFFFFFFC; #1; chk("incwrap", adder_out, 32'h00000000);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
